// File: rtl/phivers_injector.sv
// Store-and-forward NoC packet injector: buffers a source packet, then emits header, size and payload flits.
// Latency: header is presented one cycle after the last source flit is accepted.
// Backpressure: src_ready_o is low while sending; NoC flits hold stable until credit_i is high.
module phivers_injector #(
    parameter int unsigned FLIT_SIZE   = 32,
    parameter int unsigned BUFFER_SIZE = 16,
    parameter logic [15:0] TARGET_ADDR = 16'h0101
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    input  logic                 src_last_i,
    output logic                 tx_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [15:0]          pkt_count_o
);

    localparam int unsigned AW = $clog2(BUFFER_SIZE);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HEADER,
        ST_SIZE,
        ST_PAYLOAD
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   rd_idx_q, rd_idx_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic            live_q, live_d;

    logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];

    logic            src_xfer;
    logic            noc_xfer;
    logic            last_flit;
    logic            store_en;
    logic [AW-1:0]   wr_addr;

    assign src_xfer  = src_valid_i & src_ready_o;
    assign noc_xfer  = tx_o & credit_i;
    assign last_flit = (rd_idx_q == (cnt_q - CW'(1)));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (src_xfer) begin
                    state_d = src_last_i ? ST_HEADER : ST_FILL;
                end
            end
            ST_FILL: begin
                if (src_xfer && src_last_i) begin
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (noc_xfer) begin
                    state_d = ST_SIZE;
                end
            end
            ST_SIZE: begin
                if (noc_xfer) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (noc_xfer && last_flit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs; live_q keeps src_ready_o low until the first edge after reset release.
    always_comb begin
        src_ready_o = 1'b0;
        tx_o        = 1'b0;
        data_o      = '0;
        busy_o      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE, ST_FILL: begin
                src_ready_o = live_q;
            end
            ST_HEADER: begin
                tx_o         = 1'b1;
                data_o[15:0] = TARGET_ADDR;
            end
            ST_SIZE: begin
                tx_o           = 1'b1;
                data_o[CW-1:0] = cnt_q;
            end
            ST_PAYLOAD: begin
                tx_o   = 1'b1;
                data_o = mem_q[rd_idx_q[AW-1:0]];
            end
            default: begin
                tx_o = 1'b0;
            end
        endcase
    end

    assign overflow_o  = ovf_q;
    assign pkt_count_o = pkt_cnt_q;

    // Datapath next values; flits beyond a full buffer are swallowed and flagged.
    always_comb begin
        live_d    = 1'b1;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        ovf_d     = ovf_q;
        pkt_cnt_d = pkt_cnt_q;
        store_en  = 1'b0;
        wr_addr   = '0;

        if (src_xfer) begin
            if (state_q == ST_IDLE) begin
                store_en = 1'b1;
                wr_addr  = '0;
                cnt_d    = CW'(1);
            end else if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                store_en = 1'b1;
                wr_addr  = cnt_q[AW-1:0];
                cnt_d    = cnt_q + CW'(1);
            end
        end

        if (noc_xfer) begin
            if (state_q == ST_SIZE) begin
                rd_idx_d = '0;
            end else if (state_q == ST_PAYLOAD) begin
                if (last_flit) begin
                    rd_idx_d  = '0;
                    cnt_d     = '0;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end else begin
                    rd_idx_d = rd_idx_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            ovf_q     <= 1'b0;
            pkt_cnt_q <= '0;
            live_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            ovf_q     <= ovf_d;
            pkt_cnt_q <= pkt_cnt_d;
            live_q    <= live_d;
        end
    end

    // Payload storage carries no reset; stale slots are never read.
    always_ff @(posedge clk_i) begin
        if (store_en) begin
            mem_q[wr_addr] <= src_data_i;
        end
    end

endmodule

// File: tb/tb_phivers_injector.sv
// Bench for phivers_injector: randomized packets checked against a queue-based packet model.
module tb_phivers_injector;

    localparam int          FS = 32;
    localparam int          BS = 16;
    localparam logic [15:0] TA = 16'h0101;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          src_valid_i = 1'b0;
    logic          src_ready_o;
    logic [FS-1:0] src_data_i = '0;
    logic          src_last_i = 1'b0;
    logic          tx_o;
    logic [FS-1:0] data_o;
    logic          credit_i = 1'b0;
    logic          busy_o;
    logic          overflow_o;
    logic [15:0]   pkt_count_o;

    phivers_injector #(.FLIT_SIZE(FS), .BUFFER_SIZE(BS), .TARGET_ADDR(TA)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
        .src_data_i(src_data_i), .src_last_i(src_last_i),
        .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i),
        .busy_o(busy_o), .overflow_o(overflow_o), .pkt_count_o(pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [FS-1:0] got_q[$];
    logic [FS-1:0] exp_q[$];
    logic [FS-1:0] pk_dat[$];
    int            pk_len[$];
    int            hold_err = 0;
    bit            prev_stall = 0;
    logic [FS-1:0] prev_dat = '0;
    int            credit_mode = 0;
    bit            stop_credit = 0;
    bit            src_timeout = 0;
    logic [15:0]   m_pkts = 16'd0;
    bit            m_ovf = 0;
    bit            to;

    // NoC monitor: a flit counts when tx_o and credit_i are both high before the edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (prev_stall && (!tx_o || data_o !== prev_dat)) hold_err++;
            if (tx_o && credit_i) got_q.push_back(data_o);
            prev_stall = tx_o && !credit_i;
            prev_dat   = data_o;
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: each packet yields header, min(n,BS), then its first min(n,BS) flits.
    function automatic void build_expect();
        int base;
        int k;
        base = 0;
        exp_q.delete();
        foreach (pk_len[p]) begin
            k = (pk_len[p] > BS) ? BS : pk_len[p];
            exp_q.push_back(FS'(TA));
            exp_q.push_back(FS'(k));
            for (int i = 0; i < k; i++) exp_q.push_back(pk_dat[base + i]);
            if (pk_len[p] > BS) m_ovf = 1;
            m_pkts = m_pkts + 16'd1;
            base += pk_len[p];
        end
    endfunction

    task automatic new_packets(input int n_pk, input int min_len, input int max_len);
        int n;
        pk_dat.delete();
        pk_len.delete();
        for (int p = 0; p < n_pk; p++) begin
            n = $urandom_range(max_len, min_len);
            pk_len.push_back(n);
            for (int i = 0; i < n; i++) pk_dat.push_back(FS'($urandom));
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_src(input logic [FS-1:0] d, input bit last, input bit gaps);
        int guard;
        bit rdy;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i);
                #1;
            end
        end
        src_valid_i = 1'b1;
        src_data_i  = d;
        src_last_i  = last;
        rdy   = 0;
        guard = 0;
        while (!rdy && guard < 2000) begin
            @(negedge clk_i);
            rdy = src_ready_o;
            @(posedge clk_i);
            #1;
            guard++;
        end
        src_valid_i = 1'b0;
        src_last_i  = 1'b0;
        if (!rdy) src_timeout = 1;
    endtask

    task automatic run_packets(input int mode, input bit gaps, output bit timed_out);
        int want;
        int budget;
        got_q.delete();
        src_timeout = 0;
        build_expect();
        want = exp_q.size();
        credit_mode = mode;
        stop_credit = 0;
        fork
            begin
                int base = 0;
                foreach (pk_len[p]) begin
                    for (int i = 0; i < pk_len[p]; i++)
                        drive_src(pk_dat[base + i], i == pk_len[p] - 1, gaps);
                    base += pk_len[p];
                end
            end
            begin
                int pidx = 0;
                while (!stop_credit) begin
                    case (credit_mode)
                        1:       credit_i = 1'($urandom_range(1, 0));
                        2:       credit_i = (pidx % 4 == 0) || (pidx % 4 == 3);
                        default: credit_i = 1'b1;
                    endcase
                    pidx++;
                    @(posedge clk_i);
                    #1;
                end
            end
        join_none
        budget = 0;
        while (got_q.size() < want && budget < 20 * want + 200) begin
            @(posedge clk_i);
            #1;
            budget++;
        end
        repeat (6) begin
            @(posedge clk_i);
            #1;
        end
        stop_credit = 1;
        wait fork;
        credit_i = 1'b1;
        timed_out = (got_q.size() < want) || src_timeout;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (src_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", src_ready_o); end
        n_cmp++; if (tx_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL rst_tx_busy got %b%b want 00", tx_o, busy_o); end
        n_cmp++; if (data_o !== '0) begin n_err++; $display("FAIL rst_data got %h want 0", data_o); end
        n_cmp++; if (overflow_o !== 1'b0 || pkt_count_o !== 16'd0) begin n_err++; $display("FAIL rst_ovf_cnt got %b/%h want 0/0", overflow_o, pkt_count_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (src_ready_o !== 1'b0) begin n_err++; $display("FAIL rel_ready_early got %b want 0", src_ready_o); end
        @(posedge clk_i);
        #1;
        n_cmp++; if (src_ready_o !== 1'b1) begin n_err++; $display("FAIL rel_ready_edge got %b want 1", src_ready_o); end
        m_pkts = 16'd0;
        m_ovf  = 0;
    endtask

    task automatic test_basic();
        new_packets(1, 3, 3);
        run_packets(0, 0, to);
        n_cmp++; if (to || got_q.size() != 5) begin n_err++; $display("FAIL basic_len got %0d want 5", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_flit%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (pkt_count_o !== 16'd1) begin n_err++; $display("FAIL basic_pkts got %0d want 1", pkt_count_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy got %b want 0", busy_o); end
    endtask

    task automatic test_single();
        int g;
        new_packets(1, 1, 1);
        got_q.delete();
        build_expect();
        credit_i = 1'b1;
        drive_src(pk_dat[0], 1'b1, 1'b0);
        n_cmp++; if (tx_o !== 1'b1 || data_o !== 32'h0000_0101) begin n_err++; $display("FAIL single_latency got tx=%b data=%h want tx=1 data=00000101", tx_o, data_o); end
        g = 0;
        while (got_q.size() < 3 && g < 50) begin @(posedge clk_i); #1; g++; end
        repeat (4) begin @(posedge clk_i); #1; end
        n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL single_len got %0d want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_flit%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (pkt_count_o !== m_pkts) begin n_err++; $display("FAIL single_pkts got %0d want %0d", pkt_count_o, m_pkts); end
    endtask

    task automatic test_credit_toggle();
        hold_err = 0;
        new_packets(1, 4, 4);
        run_packets(2, 0, to);
        n_cmp++; if (to || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL credit_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL credit_flit%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL credit_hold got %0d unstable stalls want 0", hold_err); end
        n_cmp++; if (pkt_count_o !== m_pkts) begin n_err++; $display("FAIL credit_pkts got %0d want %0d", pkt_count_o, m_pkts); end
    endtask

    task automatic test_overflow();
        new_packets(1, 20, 20);
        run_packets(0, 0, to);
        n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
        n_cmp++; if (got_q.size() < 2 || got_q[1] !== 32'h0000_0010) begin n_err++; $display("FAIL ovf_size got %h want 00000010", got_q.size() > 1 ? got_q[1] : 'x); end
        n_cmp++; if (to || got_q.size() != 18) begin n_err++; $display("FAIL ovf_len got %0d want 18", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_flit%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        new_packets(1, 2, 2);
        run_packets(0, 0, to);
        n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
        n_cmp++; if (pkt_count_o !== m_pkts) begin n_err++; $display("FAIL ovf_pkts got %0d want %0d", pkt_count_o, m_pkts); end
    endtask

    task automatic test_reset_mid();
        int g;
        new_packets(1, 5, 5);
        got_q.delete();
        credit_i = 1'b1;
        for (int i = 0; i < 5; i++) drive_src(pk_dat[i], i == 4, 1'b0);
        g = 0;
        while (got_q.size() < 4 && g < 50) begin @(posedge clk_i); #1; g++; end
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (tx_o !== 1'b0) begin n_err++; $display("FAIL mid_tx got %b want 0", tx_o); end
        n_cmp++; if (pkt_count_o !== 16'd0 || overflow_o !== 1'b0) begin n_err++; $display("FAIL mid_clear got %h/%b want 0/0", pkt_count_o, overflow_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        m_pkts = 16'd0;
        m_ovf  = 0;
        new_packets(1, 2, 2);
        run_packets(1, 0, to);
        n_cmp++; if (to || got_q.size() != 4) begin n_err++; $display("FAIL mid_len got %0d want 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_flit%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (pkt_count_o !== 16'd1) begin n_err++; $display("FAIL mid_pkts got %0d want 1", pkt_count_o); end
    endtask

    task automatic test_random();
        hold_err = 0;
        new_packets(25, 1, 20);
        run_packets(1, 1, to);
        n_cmp++; if (to || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_flit%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (pkt_count_o !== m_pkts) begin n_err++; $display("FAIL rand_pkts got %0d want %0d", pkt_count_o, m_pkts); end
        n_cmp++; if (overflow_o !== m_ovf) begin n_err++; $display("FAIL rand_ovf got %b want %b", overflow_o, m_ovf); end
        n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL rand_hold got %0d unstable stalls want 0", hold_err); end
    endtask

    // Preload the packet counter near its limit rather than sending 65534 packets.
    task automatic test_wrap();
        force dut.pkt_cnt_q = 16'hFFFE;
        @(posedge clk_i);
        #1;
        release dut.pkt_cnt_q;
        m_pkts = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            new_packets(1, 1, 1);
            run_packets(0, 0, to);
            n_cmp++; if (to || pkt_count_o !== m_pkts) begin n_err++; $display("FAIL wrap_pkts%0d got %h want %h", k, pkt_count_o, m_pkts); end
            if (k == 1) begin
                n_cmp++; if (pkt_count_o !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", pkt_count_o); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_credit_toggle();
        test_overflow();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phivers_injector.md
PHIVERS_INJECTOR -- requirements
Module: phivers_injector

Interface
REQ-001 The block SHALL expose parameter FLIT_SIZE, default 32, meaning data width in bits of source and NoC flits (minimum 16).
REQ-002 The block SHALL expose parameter BUFFER_SIZE, default 16, meaning payload buffer depth in flits (power of two, minimum 2).
REQ-003 The block SHALL expose parameter TARGET_ADDR, 16 bits, default 16'h0101, meaning the destination router address placed in every header flit.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port src_valid_i, input, 1 bit: a source flit is offered.
REQ-007 The block SHALL have port src_ready_o, output, 1 bit: the block accepts the source flit this cycle.
REQ-008 The block SHALL have port src_data_i, input, FLIT_SIZE bits: source payload flit.
REQ-009 The block SHALL have port src_last_i, input, 1 bit: the offered flit is the final payload flit of its packet.
REQ-010 The block SHALL have port tx_o, output, 1 bit: a NoC flit is presented on data_o.
REQ-011 The block SHALL have port data_o, output, FLIT_SIZE bits: NoC flit.
REQ-012 The block SHALL have port credit_i, input, 1 bit: the router can accept a flit this cycle.
REQ-013 The block SHALL have port busy_o, output, 1 bit: the block is not in IDLE.
REQ-014 The block SHALL have port overflow_o, output, 1 bit: sticky flag set when a packet exceeded BUFFER_SIZE.
REQ-015 The block SHALL have port pkt_count_o, output, 16 bits: count of packets fully transmitted.

Function
REQ-016 The block SHALL implement states IDLE, FILL, HEADER, SIZE and PAYLOAD.
REQ-017 Source transfer SHALL occur when src_valid_i and src_ready_o are both 1; src_ready_o SHALL be 1 only in IDLE and FILL.
REQ-018 In IDLE, a source transfer SHALL write the flit to buffer slot 0 and set stored count to 1, moving to FILL, or to HEADER if src_last_i is 1.
REQ-019 In FILL, each source transfer SHALL store the flit at the next slot and increment stored count; a transfer with src_last_i=1 SHALL move to HEADER the following cycle.
REQ-020 A source transfer arriving when stored count equals BUFFER_SIZE SHALL be accepted and discarded, and SHALL set overflow_o; if it carries src_last_i=1 it SHALL still end the packet.
REQ-021 NoC transfer SHALL occur when tx_o and credit_i are both 1; tx_o SHALL be 1 only in HEADER, SIZE and PAYLOAD.
REQ-022 In HEADER, data_o SHALL be TARGET_ADDR zero-extended to FLIT_SIZE; on transfer the block SHALL move to SIZE.
REQ-023 In SIZE, data_o SHALL be the stored count zero-extended to FLIT_SIZE; on transfer the block SHALL move to PAYLOAD with read index 0.
REQ-024 In PAYLOAD, data_o SHALL be the buffer slot at the read index; on each transfer the read index SHALL increment.
REQ-025 On the transfer of the final stored flit, the block SHALL return to IDLE and increment pkt_count_o by 1, wrapping 16'hFFFF to 16'h0000.
REQ-026 While tx_o=1 and credit_i=0, data_o and the state SHALL hold unchanged.
REQ-027 Store-and-forward SHALL apply: no NoC flit SHALL be emitted before src_last_i of the current packet has been accepted.
REQ-028 The minimum latency from acceptance of a 1-flit last packet to tx_o=1 with the header SHALL be one cycle.
REQ-029 Counters and indices SHALL be sized $clog2(BUFFER_SIZE)+1 bits so that count BUFFER_SIZE is representable.

Reset
REQ-030 While rst_ni=0, the block SHALL force state IDLE, src_ready_o=0, tx_o=0, data_o=0, busy_o=0, overflow_o=0, pkt_count_o=0, and stored count and read index to 0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet, with no further flits emitted after deassertion.
REQ-032 src_ready_o SHALL become 1 on the first clock edge after rst_ni deasserts; buffer contents need not be cleared.

Verification
REQ-033 Reset, then a 3-flit packet A1,A2,A3 with credit_i=1 -> data_o sequence 0x00000101, 0x00000003, A1, A2, A3; pkt_count_o=1; busy_o=0 afterwards.
REQ-034 A 1-flit packet with src_last_i=1 -> header and size 0x00000001, then the flit; tx_o=1 one cycle after acceptance.
REQ-035 A 4-flit packet with credit_i toggling 1,0,0,1 -> every flit held stable while credit_i=0; order and count unchanged; no flit duplicated.
REQ-036 A 20-flit packet with BUFFER_SIZE=16 -> overflow_o=1 stays set; size flit 0x00000010; the first 16 flits are sent.
REQ-037 Reset asserted during PAYLOAD of a 5-flit packet -> tx_o=0 immediately; after release the next 2-flit packet is sent correctly and pkt_count_o=1.
REQ-038 65536 one-flit packets -> pkt_count_o wraps to 0.
